// File: rtl/addsub_pkg.sv
// rtl/addsub_pkg.sv - shared FSM state, operand width and opcode constants for addsub_arbiter
package addsub_pkg;

  localparam int WIDTH = 4;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    HOLD = 2'd2
  } state_t;

endpackage

// File: rtl/addsub4.sv
// rtl/addsub4.sv - combinational 4-bit ripple adder/subtractor; sub inverts b and injects carry-in
module addsub4 import addsub_pkg::*; (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             c3
);

  logic [WIDTH:0]   carry;
  logic [WIDTH-1:0] b_eff;

  assign b_eff    = b ^ {WIDTH{sub}};
  assign carry[0] = sub;

  for (genvar i = 0; i < WIDTH; i++) begin : g_fa
    assign sum[i]     = a[i] ^ b_eff[i] ^ carry[i];
    assign carry[i+1] = (a[i] & b_eff[i]) | (carry[i] & (a[i] ^ b_eff[i]));
  end

  assign cout = carry[WIDTH];
  assign c3   = carry[WIDTH-1];

endmodule

// File: rtl/addsub_arbiter.sv
// rtl/addsub_arbiter.sv - two-requester round-robin add/sub unit with held response
// Optional signed-overflow output enabled by macro ADDSUB_ARBITER_OVF_EN.
module addsub_arbiter import addsub_pkg::*; #(
  parameter logic RR_INIT = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic             req0_sub,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic             req1_sub,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_sum,
  output logic             rsp_cout
`ifdef ADDSUB_ARBITER_OVF_EN
  ,
  output logic             rsp_ovf
`endif
);

  state_t           state;
  logic             prio;
  logic             op_sub;
  logic             op_id;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             c3;
  logic             any_valid;
  logic             grant_id;

`ifndef ADDSUB_ARBITER_OVF_EN
  logic c3_unused;
  assign c3_unused = c3;
`endif

  // A lone requester wins regardless of priority; contention goes to prio.
  assign any_valid  = req0_valid | req1_valid;
  assign grant_id   = (req0_valid & req1_valid) ? prio : req1_valid;
  assign req0_ready = rst_n & (state == IDLE) & any_valid & ~grant_id;
  assign req1_ready = rst_n & (state == IDLE) & any_valid & grant_id;

  addsub4 u_addsub4 (
    .a    (op_a),
    .b    (op_b),
    .sub  (op_sub),
    .sum  (sum),
    .cout (cout),
    .c3   (c3)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      prio      <= RR_INIT;
      op_sub    <= OP_ADD;
      op_id     <= 1'b0;
      op_a      <= '0;
      op_b      <= '0;
      rsp_valid <= 1'b0;
      rsp_id    <= 1'b0;
      rsp_sum   <= '0;
      rsp_cout  <= 1'b0;
`ifdef ADDSUB_ARBITER_OVF_EN
      rsp_ovf   <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (any_valid) begin
            op_id  <= grant_id;
            op_sub <= grant_id ? req1_sub : req0_sub;
            op_a   <= grant_id ? req1_a   : req0_a;
            op_b   <= grant_id ? req1_b   : req0_b;
            state  <= EXEC;
          end
        end
        EXEC: begin
          rsp_valid <= 1'b1;
          rsp_id    <= op_id;
          rsp_sum   <= sum;
          rsp_cout  <= cout;
`ifdef ADDSUB_ARBITER_OVF_EN
          rsp_ovf   <= c3 ^ cout;
`endif
          state     <= HOLD;
        end
        HOLD: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            prio      <= ~rsp_id;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
